// File: rtl/dsp_addsub_multiword_pkg.sv
// Shared constants and type definitions for the multi-word add/subtract unit.
package dsp_addsub_multiword_pkg;

  localparam int unsigned LIMB_W = 32;

  typedef enum logic {
    DSP_OP_ADD = 1'b0,
    DSP_OP_SUB = 1'b1
  } dsp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dsp_addsub_multiword_if.sv
// Operand/result handshake bundle of the multi-word add/subtract unit.
interface dsp_addsub_multiword_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op, input1, input2, out_ready,
    input  in_ready, out_valid, out, co, ovf, zero
  );

  modport slave (
    input  in_valid, op, input1, input2, out_ready,
    output in_ready, out_valid, out, co, ovf, zero
  );
endinterface

// File: rtl/dsp_addsub_multiword_add32.sv
// 32-bit adder with carry-in; combinational equivalent of one SB_MAC16 in 32-bit add mode.
module dsp_add32
  import dsp_addsub_multiword_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              ci,
  output logic [LIMB_W-1:0] s,
  output logic              co
);
  localparam int unsigned HALF = LIMB_W / 2;

  logic [HALF-1:0] s_lo;
  logic [HALF-1:0] s_hi;
  logic            c_lo;

  // Bottom-half carry cascades into the top half, as with TOPADDSUB_CARRYSELECT=2.
  always_comb begin
    {c_lo, s_lo} = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, ci};
    {co, s_hi}   = {1'b0, a[LIMB_W-1:HALF]} + {1'b0, b[LIMB_W-1:HALF]} + {{HALF{1'b0}}, c_lo};
    s            = {s_hi, s_lo};
  end
endmodule

// File: rtl/dsp_addsub_multiword.sv
// Multi-precision add/subtract: one 32-bit limb per cycle through dsp_add32, LS limb first.
module dsp_addsub_multiword
  import dsp_addsub_multiword_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input logic                     clk,
  input logic                     reset,
  dsp_addsub_multiword_if.slave   bus
);
  localparam int unsigned NLIMB = WIDTH / LIMB_W;
  localparam int unsigned IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  if ((WIDTH % LIMB_W) != 0 || WIDTH < LIMB_W) begin : g_bad_width
    $error("dsp_addsub_multiword: WIDTH must be a multiple of 32 and >= 32");
  end

  state_e            state, state_nxt;
  logic [WIDTH-1:0]  a_sh, b_sh, result;
  logic [IDXW-1:0]   idx;
  logic              carry, zacc;
  logic              co_q, ovf_q, zero_q;
  logic [LIMB_W-1:0] sum;
  logic              sum_co;
  logic              last;

  dsp_add32 u_add (
    .a  (a_sh[LIMB_W-1:0]),
    .b  (b_sh[LIMB_W-1:0]),
    .ci (carry),
    .s  (sum),
    .co (sum_co)
  );

  assign last = (idx == IDXW'(NLIMB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      result <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sh  <= bus.input1;
          b_sh  <= (bus.op == DSP_OP_SUB) ? ~bus.input2 : bus.input2;
          carry <= bus.op;
          idx   <= '0;
          zacc  <= 1'b0;
        end
        CALC: begin
          result[idx*LIMB_W +: LIMB_W] <= sum;
          carry <= sum_co;
          a_sh  <= a_sh >> LIMB_W;
          b_sh  <= b_sh >> LIMB_W;
          idx   <= idx + 1'b1;
          zacc  <= zacc | (|sum);
          // On the last limb the shifters hold the top limb, so bit 31 is the operand sign.
          if (last) begin
            co_q   <= sum_co;
            ovf_q  <= (a_sh[LIMB_W-1] == b_sh[LIMB_W-1]) & (sum[LIMB_W-1] != a_sh[LIMB_W-1]);
            zero_q <= ~(zacc | (|sum));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = result;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_dsp_addsub_multiword.sv
// Directed and randomised checks of dsp_addsub_multiword at WIDTH=64 and WIDTH=32.
module tb_dsp_addsub_multiword;

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_out;
    logic        exp_co;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dsp_addsub_multiword_if #(.WIDTH(64)) if64 ();
  dsp_addsub_multiword_if #(.WIDTH(32)) if32 ();

  dsp_addsub_multiword #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(if64));
  dsp_addsub_multiword #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input bit w32, input logic op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output logic c, output logic v, output logic z,
                        output int lat);
    int unsigned guard;
    @(negedge clk);
    if (w32) begin
      if32.op = op; if32.input1 = a[31:0]; if32.input2 = b[31:0]; if32.in_valid = 1'b1;
    end else begin
      if64.op = op; if64.input1 = a; if64.input2 = b; if64.in_valid = 1'b1;
    end
    guard = 0;
    while (!(w32 ? if32.in_ready : if64.in_ready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("accept_timeout", 64'(guard), 64'd0);
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    if64.in_valid = 1'b0;
    lat = 0;
    while (!(w32 ? if32.out_valid : if64.out_valid) && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = w32 ? {32'd0, if32.out} : if64.out;
    c = w32 ? if32.co   : if64.co;
    v = w32 ? if32.ovf  : if64.ovf;
    z = w32 ? if32.zero : if64.zero;
    @(negedge clk);
    if32.out_ready = 1'b1;
    if64.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if32.out_ready = 1'b0;
    if64.out_ready = 1'b0;
  endtask

  task automatic model(input bit w32, input logic op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic c, output logic v, output logic z);
    logic [64:0] s65;
    logic [32:0] s33;
    if (w32) begin
      s33 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
      r = op ? {32'd0, a[31:0] - b[31:0]} : {32'd0, s33[31:0]};
      c = op ? (a[31:0] >= b[31:0]) : s33[32];
      v = op ? ((a[31] != b[31]) && (r[31] != a[31])) : ((a[31] == b[31]) && (r[31] != a[31]));
    end else begin
      s65 = {1'b0, a} + {1'b0, b};
      r = op ? a - b : s65[63:0];
      c = op ? (a >= b) : s65[64];
      v = op ? ((a[63] != b[63]) && (r[63] != a[63])) : ((a[63] == b[63]) && (r[63] != a[63]));
    end
    z = (r == 64'd0);
  endtask

  vec_t        vecs[10];
  logic [63:0] r, er, a, b;
  logic        c, v, z, ec, ev, ez, op;
  int          lat;

  initial begin
    if64.in_valid = 1'b0; if64.op = 1'b0; if64.input1 = '0; if64.input2 = '0; if64.out_ready = 1'b0;
    if32.in_valid = 1'b0; if32.op = 1'b0; if32.input1 = '0; if32.input2 = '0; if32.out_ready = 1'b0;

    vecs[0] = '{1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 64'h00000001_00000000, 64'h1, 64'h00000000_FFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 64'h0, 64'h1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 64'h5, 64'h3, 64'h2, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 64'h80000000_00000000, 64'h1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000000, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 64'h00000001_00000000, 64'h0, 64'h00000001_00000000, 1'b0, 1'b0, 1'b0};

    #12;
    check("rst_out",       if64.out, 64'h0);
    check("rst_out_valid", 64'(if64.out_valid), 64'd0);
    check("rst_in_ready",  64'(if64.in_ready), 64'd1);
    check("rst_flags",     64'({if64.co, if64.ovf, if64.zero}), 64'd0);
    check("rst_in_ready32", 64'(if32.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, r, c, v, z, lat);
      check($sformatf("vec%0d_out", i),  r, vecs[i].exp_out);
      check($sformatf("vec%0d_co", i),   64'(c), 64'(vecs[i].exp_co));
      check($sformatf("vec%0d_ovf", i),  64'(v), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_zero", i), 64'(z), 64'(vecs[i].exp_zero));
      check($sformatf("vec%0d_lat", i),  64'(lat), 64'd2);
    end

    // Backpressure: result held while in_valid/input1 wiggle.
    @(negedge clk);
    if64.op = 1'b0; if64.input1 = 64'h12345678_9ABCDEF0; if64.input2 = 64'h11111111_11111111;
    if64.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if64.in_valid = 1'b0;
    lat = 0;
    while (!if64.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if64.in_valid = ~if64.in_valid;
      if64.input1 = ~if64.input1;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out", k), if64.out, 64'h23456789_ABCDF001);
      check($sformatf("bp%0d_flags", k), 64'({if64.co, if64.ovf, if64.zero}), 64'd0);
      check($sformatf("bp%0d_in_ready", k), 64'(if64.in_ready), 64'd0);
      check($sformatf("bp%0d_out_valid", k), 64'(if64.out_valid), 64'd1);
    end
    @(negedge clk);
    if64.in_valid = 1'b0;
    if64.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if64.out_ready = 1'b0;
    check("bp_release_valid", 64'(if64.out_valid), 64'd0);
    check("bp_release_ready", 64'(if64.in_ready), 64'd1);
    check("bp_release_out", if64.out, 64'h23456789_ABCDF001);

    // Reset pulse mid-CALC discards the operation.
    @(negedge clk);
    if64.op = 1'b0; if64.input1 = 64'hFFFF0000_FFFF0000; if64.input2 = 64'h1; if64.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if64.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(if64.out_valid), 64'd0);
    check("mid_rst_out", if64.out, 64'h0);
    check("mid_rst_in_ready", 64'(if64.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 1'b1, 64'd5, 64'd3, r, c, v, z, lat);
    check("post_rst_out", r, 64'd2);
    check("post_rst_co", 64'(c), 64'd1);

    // WIDTH=32 build.
    run_op(1'b1, 1'b1, 64'h80000000, 64'h1, r, c, v, z, lat);
    check("w32_out", r, 64'h7FFFFFFF);
    check("w32_ovf", 64'(v), 64'd1);
    check("w32_co",  64'(c), 64'd1);
    check("w32_lat", 64'(lat), 64'd1);

    for (int i = 0; i < 40; i++) begin
      bit w32;
      w32 = (i % 2) == 0;
      a = {$urandom, $urandom};
      b = (i % 7 == 3) ? a : {$urandom, $urandom};
      op = 1'($urandom_range(0, 1));
      model(w32, op, a, b, er, ec, ev, ez);
      run_op(w32, op, a, b, r, c, v, z, lat);
      check($sformatf("rnd%0d_out", i), r, er);
      check($sformatf("rnd%0d_flags", i), 64'({c, v, z}), 64'({ec, ev, ez}));
      check($sformatf("rnd%0d_lat", i), 64'(lat), w32 ? 64'd1 : 64'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
